// File: rtl/pipe_sched.sv
// Pipeline scheduler for the 5-stage MIPS core: per-stage enables/flushes from hazards, redirects, MDU and halt.
// Optional front-end stall counter is built only when PERF_STALL_CNT_EN is defined.
module pipe_sched #(
   parameter int MDU_TIMEOUT = 64,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   ID_jump,
   input  logic                   EX_mdu,
   input  logic                   mdu_done,
   input  logic                   WB_halt,
   output logic                   PC_en,
   output logic                   IF_ID_en,
   output logic                   ID_EX_en,
   output logic                   EX_ME_en,
   output logic                   ME_WB_en,
   output logic                   IF_ID_flush,
   output logic                   ID_EX_flush,
   output logic                   EX_ME_flush,
   output logic                   mdu_go,
   output logic                   halted,
   output logic                   mdu_err,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int WAIT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              err_set;

   always_comb begin
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_ME_en     = 1'b0;
      ME_WB_en     = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_ME_flush  = 1'b0;
      mdu_go       = 1'b0;
      err_set      = 1'b0;
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;

      if (rst) begin
         state_nxt    = RUN;
         wait_cnt_nxt = '0;
      end else begin
         case (state)
            RUN: begin
               if (WB_halt) begin
                  state_nxt = HALT;
               end else if (EX_mdu) begin
                  // Hold the MDU op in EX while older instructions drain past it.
                  mdu_go       = 1'b1;
                  EX_ME_en     = 1'b1;
                  ME_WB_en     = 1'b1;
                  EX_ME_flush  = 1'b1;
                  state_nxt    = MDU_WAIT;
                  wait_cnt_nxt = '0;
               end else begin
                  PC_en    = 1'b1;
                  IF_ID_en = 1'b1;
                  ID_EX_en = 1'b1;
                  EX_ME_en = 1'b1;
                  ME_WB_en = 1'b1;
                  if (stall) begin
                     PC_en       = 1'b0;
                     IF_ID_en    = 1'b0;
                     ID_EX_flush = 1'b1;
                  end else if (ID_jump) begin
                     IF_ID_flush = 1'b1;
                  end
               end
            end

            MDU_WAIT: begin
               if (WB_halt) begin
                  state_nxt = HALT;
               end else if (mdu_done) begin
                  PC_en     = 1'b1;
                  IF_ID_en  = 1'b1;
                  ID_EX_en  = 1'b1;
                  EX_ME_en  = 1'b1;
                  ME_WB_en  = 1'b1;
                  state_nxt = RUN;
                  if (stall) begin
                     PC_en       = 1'b0;
                     IF_ID_en    = 1'b0;
                     ID_EX_flush = 1'b1;
                  end else if (ID_jump) begin
                     IF_ID_flush = 1'b1;
                  end
               end else begin
                  EX_ME_en     = 1'b1;
                  ME_WB_en     = 1'b1;
                  EX_ME_flush  = 1'b1;
                  wait_cnt_nxt = wait_cnt + 1'b1;
                  if (wait_cnt == WAIT_LAST) begin
                     state_nxt = HALT;
                     err_set   = 1'b1;
                  end
               end
            end

            HALT: begin
               state_nxt = HALT;
            end

            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         halted   <= 1'b0;
         mdu_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state_nxt == HALT) begin
            halted <= 1'b1;
         end
         if (err_set) begin
            mdu_err <= 1'b1;
         end
      end
   end

`ifdef PERF_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The HALT entry cycle still counts: state is RUN/MDU_WAIT there with PC_en low.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!PC_en && (state != HALT)) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched (MDU_TIMEOUT=8); expected values are hand-computed per step.
`timescale 1ns/1ps
module tb_pipe_sched;

   localparam int SCW = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           stall = 1'b0;
   logic           ID_jump = 1'b0;
   logic           EX_mdu = 1'b0;
   logic           mdu_done = 1'b0;
   logic           WB_halt = 1'b0;
   logic           PC_en, IF_ID_en, ID_EX_en, EX_ME_en, ME_WB_en;
   logic           IF_ID_flush, ID_EX_flush, EX_ME_flush;
   logic           mdu_go, halted, mdu_err;
   logic [SCW-1:0] stall_cycles;

   int checks   = 0;
   int failures = 0;

   pipe_sched #(.MDU_TIMEOUT(8), .STALL_CNT_W(SCW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .ID_jump(ID_jump), .EX_mdu(EX_mdu),
      .mdu_done(mdu_done), .WB_halt(WB_halt),
      .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_ME_en(EX_ME_en),
      .ME_WB_en(ME_WB_en), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
      .EX_ME_flush(EX_ME_flush), .mdu_go(mdu_go), .halted(halted), .mdu_err(mdu_err),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // {PC, IF_ID, ID_EX, EX_ME, ME_WB} and {IF_ID, ID_EX, EX_ME}
   wire [4:0] en = {PC_en, IF_ID_en, ID_EX_en, EX_ME_en, ME_WB_en};
   wire [2:0] fl = {IF_ID_flush, ID_EX_flush, EX_ME_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [4:0] e_en, input logic [2:0] e_fl,
                          input logic e_go);
      chk({tag, "_en"}, 32'(en), 32'(e_en));
      chk({tag, "_fl"}, 32'(fl), 32'(e_fl));
      chk({tag, "_go"}, 32'(mdu_go), 32'(e_go));
   endtask

   task automatic chk_st(input string tag, input logic e_halted, input logic e_err);
      chk({tag, "_halted"}, 32'(halted), 32'(e_halted));
      chk({tag, "_err"}, 32'(mdu_err), 32'(e_err));
   endtask

   function automatic logic [31:0] exp_sc(input int n);
`ifdef PERF_STALL_CNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   // One cycle: drive inputs just after the rising edge, sample mid-cycle.
   task automatic step(input logic r, input logic s, input logic j, input logic m,
                       input logic d, input logic h);
      @(posedge clk);
      #1;
      rst = r; stall = s; ID_jump = j; EX_mdu = m; mdu_done = d; WB_halt = h;
      #2;
   endtask

   initial begin
      // reset with stall high: everything forced off
      step(1, 1, 0, 0, 0, 0);
      chk_out("rst", 5'b00000, 3'b000, 0);
      chk_st("rst", 0, 0);
      chk("rst_sc", stall_cycles, 32'd0);

      step(0, 0, 0, 0, 0, 0);
      chk_out("release", 5'b11111, 3'b000, 0);
      chk_st("release", 0, 0);

      // stall held three cycles
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0, 0);
         chk_out("stall", 5'b00111, 3'b010, 0);
      end
      step(0, 0, 0, 0, 0, 0);
      chk_out("stall_end", 5'b11111, 3'b000, 0);
      chk("stall_sc", stall_cycles, exp_sc(3));

      // redirect alone, then redirect under a stall
      step(0, 0, 1, 0, 0, 0);
      chk_out("jump", 5'b11111, 3'b100, 0);
      step(0, 1, 1, 0, 0, 0);
      chk_out("jump_stall", 5'b00111, 3'b010, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("idle1", 5'b11111, 3'b000, 0);
      chk("jump_sc", stall_cycles, exp_sc(4));

      // stray mdu_done in RUN
      step(0, 0, 0, 0, 1, 0);
      chk_out("done_run", 5'b11111, 3'b000, 0);

      // MDU op, 5 wait cycles, then done; stall/jump ignored while frozen
      step(0, 1, 1, 1, 0, 0);
      chk_out("mdu_go", 5'b00011, 3'b001, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, i[0], 1, 1, 0, 0);
         chk_out("mdu_wait", 5'b00011, 3'b001, 0);
      end
      step(0, 0, 0, 1, 1, 0);
      chk_out("mdu_done", 5'b11111, 3'b000, 0);
      step(0, 1, 0, 0, 0, 0);
      chk_out("after_done", 5'b00111, 3'b010, 0);
      chk("mdu_sc", stall_cycles, exp_sc(10));
      step(0, 0, 0, 0, 0, 0);
      chk("mdu_sc2", stall_cycles, exp_sc(11));

      // done on the last allowed wait cycle beats the timeout
      step(0, 0, 0, 1, 0, 0);
      chk_out("bnd_go", 5'b00011, 3'b001, 1);
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 0, 1, 0, 0);
      end
      step(0, 0, 0, 1, 1, 0);
      chk_out("bnd_done", 5'b11111, 3'b000, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("bnd_run", 5'b11111, 3'b000, 0);
      chk_st("bnd", 0, 0);
      chk("bnd_sc", stall_cycles, exp_sc(19));

      // timeout: 8 wait cycles without done
      step(0, 0, 0, 1, 0, 0);
      chk_out("to_go", 5'b00011, 3'b001, 1);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 1, 0, 0);
         chk_out("to_wait", 5'b00011, 3'b001, 0);
         chk_st("to_wait", 0, 0);
      end
      step(0, 1, 0, 1, 1, 0);
      chk_out("to_halt", 5'b00000, 3'b000, 0);
      chk_st("to_halt", 1, 1);
      chk("to_sc", stall_cycles, exp_sc(28));
      step(0, 0, 1, 1, 0, 0);
      chk_out("to_halt2", 5'b00000, 3'b000, 0);
      chk("to_sc2", stall_cycles, exp_sc(28));

      step(1, 0, 0, 0, 0, 0);
      chk_out("to_rst", 5'b00000, 3'b000, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("to_resume", 5'b11111, 3'b000, 0);
      chk_st("to_resume", 0, 0);
      chk("to_resume_sc", stall_cycles, 32'd0);

      // WB_halt wins over EX_mdu and stall
      step(0, 1, 0, 1, 0, 1);
      chk_out("wbh_entry", 5'b00000, 3'b000, 0);
      chk_st("wbh_entry", 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("wbh_halt", 5'b00000, 3'b000, 0);
      chk_st("wbh_halt", 1, 0);
      chk("wbh_sc", stall_cycles, exp_sc(1));
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("wbh_resume", 5'b11111, 3'b000, 0);
      chk_st("wbh_resume", 0, 0);

      // WB_halt while waiting on the MDU, even with done
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 1);
      chk_out("wbh_mdu", 5'b00000, 3'b000, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("wbh_mdu_halt", 5'b00000, 3'b000, 0);
      chk_st("wbh_mdu_halt", 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // reset in the middle of MDU_WAIT
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      chk_out("mrst_in", 5'b00000, 3'b000, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("mrst_out", 5'b11111, 3'b000, 0);
      chk_st("mrst_out", 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk_out("mrst_go", 5'b00011, 3'b001, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
